// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding imem request, a one-entry
// skid buffer for decode back-pressure, and redirect flush with stale-response drain.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        ImemReq_o,
    output logic [31:0] ImemAddr_o,
    input  logic        ImemRvalid_i,
    input  logic [31:0] ImemRdata_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectPc_i,
    output logic [31:0] Instruction_o,
    output logic [31:0] Pc_o,
    output logic        Valid_o,
    input  logic        Ready_i
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        valid_q, valid_d;
    logic [31:0] sk_instr_q, sk_instr_d;
    logic [31:0] sk_pc_q, sk_pc_d;
    logic        sk_full_q, sk_full_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        valid_d    = valid_q;
        sk_instr_d = sk_instr_q;
        sk_pc_d    = sk_pc_q;
        sk_full_d  = sk_full_q;
        if (valid_q && Ready_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
        if (Redirect_i) begin
            pc_d      = {RedirectPc_i[31:2], 2'b00};
            valid_d   = 1'b0;
            instr_d   = NOP_INSTR;
            sk_full_d = 1'b0;
            // A request still in flight must have its response swallowed first
            state_d   = ((state_q == FETCH || state_q == DRAIN) && !ImemRvalid_i) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (ImemRvalid_i) begin
                        pc_d = pc_q + 32'd4;
                        if (!valid_q || Ready_i) begin
                            instr_d = ImemRdata_i;
                            opc_d   = pc_q;
                            valid_d = 1'b1;
                        end else begin
                            sk_instr_d = ImemRdata_i;
                            sk_pc_d    = pc_q;
                            sk_full_d  = 1'b1;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (Ready_i) begin
                        instr_d   = sk_instr_q;
                        opc_d     = sk_pc_q;
                        valid_d   = 1'b1;
                        sk_full_d = 1'b0;
                        state_d   = FETCH;
                    end
                end
                default: state_d = ImemRvalid_i ? FETCH : DRAIN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            opc_q      <= 32'h0;
            valid_q    <= 1'b0;
            sk_instr_q <= NOP_INSTR;
            sk_pc_q    <= 32'h0;
            sk_full_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            opc_q      <= opc_d;
            valid_q    <= valid_d;
            sk_instr_q <= sk_instr_d;
            sk_pc_q    <= sk_pc_d;
            sk_full_q  <= sk_full_d;
        end
    end

    assign ImemReq_o     = (state_q == FETCH);
    assign ImemAddr_o    = pc_q;
    assign Instruction_o = instr_q;
    assign Pc_o          = opc_q;
    assign Valid_o       = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized memory/decode/redirect traffic,
// checked every cycle against a queue-based model of the fetch pipeline.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ImemReq_o, Valid_o, ImemRvalid_i, Redirect_i, Ready_i;
    logic [31:0] ImemAddr_o, ImemRdata_i, RedirectPc_i, Instruction_o, Pc_o;
    logic        w_req, w_valid, w_rv;
    logic [31:0] w_addr, w_instr, w_pc, w_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc, m_last;
    logic        m_idle, m_drain;
    logic        mem_out;
    int          mem_lat;

    always #5 clk_i = ~clk_i;

    fetch_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ImemReq_o(ImemReq_o), .ImemAddr_o(ImemAddr_o),
        .ImemRvalid_i(ImemRvalid_i), .ImemRdata_i(ImemRdata_i),
        .Redirect_i(Redirect_i), .RedirectPc_i(RedirectPc_i),
        .Instruction_o(Instruction_o), .Pc_o(Pc_o),
        .Valid_o(Valid_o), .Ready_i(Ready_i)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ImemReq_o(w_req), .ImemAddr_o(w_addr),
        .ImemRvalid_i(w_rv), .ImemRdata_i(w_rdata),
        .Redirect_i(1'b0), .RedirectPc_i(32'h0),
        .Instruction_o(w_instr), .Pc_o(w_pc),
        .Valid_o(w_valid), .Ready_i(1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_req();
        return !m_idle && !m_drain && q.size() < 2;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0;
        m_last  = 32'h0;
        m_idle  = 1'b1;
        m_drain = 1'b0;
        mem_out = 1'b0;
        mem_lat = 0;
    endtask

    // Fetched words form an in-order stream of at most two: the visible one and one parked behind it
    task automatic model_edge(input logic rv, input logic [31:0] rd, input logic rdy,
                              input logic redir, input logic [31:0] rpc);
        logic req;
        req = m_req();
        if (redir) begin
            q.delete();
            m_pc    = {rpc[31:2], 2'b00};
            m_drain = m_drain ? !rv : (req && !rv);
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (req && rv) begin
                q.push_back('{rd, m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (m_drain && rv) m_drain = 1'b0;
        end
        m_idle = 1'b0;
        if (q.size() > 0) m_last = q[0].pc;
    endtask

    task automatic check_all();
        chk("valid", {31'b0, Valid_o}, {31'b0, q.size() > 0});
        chk("instr", Instruction_o, q.size() > 0 ? q[0].instr : NOP);
        chk("pc", Pc_o, q.size() > 0 ? q[0].pc : m_last);
        chk("req", {31'b0, ImemReq_o}, {31'b0, m_req()});
        if (m_req()) chk("addr", ImemAddr_o, m_pc);
    endtask

    task automatic step(input logic rv, input logic [31:0] rd, input logic rdy,
                        input logic redir, input logic [31:0] rpc);
        ImemRvalid_i = rv;
        ImemRdata_i  = rd;
        Ready_i      = rdy;
        Redirect_i   = redir;
        RedirectPc_i = rpc;
        model_edge(rv, rd, rdy, redir, rpc);
        @(posedge clk_i);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        ImemRvalid_i = 1'b0;
        Redirect_i   = 1'b0;
        Ready_i      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        check_all();
    endtask

    initial begin
        ImemRdata_i  = 32'h0;
        RedirectPc_i = 32'h0;
        w_rv         = 1'b0;
        w_rdata      = 32'h00A0_0093;
        do_reset();
        chk("wrap_idle_req", {31'b0, w_req}, 32'h0);
        // Stray response in the first cycle after release must be ignored
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_first_req", {31'b0, w_req}, 32'h1);
        w_rv = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        w_rv = 1'b0;
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", w_instr, 32'h00A0_0093);
        chk("wrap_next_addr", w_addr, 32'h0000_0000);
        step(1'b1, 32'h1111_0001, 1'b1, 1'b0, 32'h0);
        chk("seq_pc0", Pc_o, 32'h0);
        chk("seq_addr4", ImemAddr_o, 32'h4);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h1111_0002, 1'b1, 1'b0, 32'h0);
        chk("seq_pc4", Pc_o, 32'h4);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h1111_0003, 1'b0, 1'b0, 32'h0);
        chk("hold_req", {31'b0, ImemReq_o}, 32'h0);
        chk("hold_pc", Pc_o, 32'h4);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("unhold_pc8", Pc_o, 32'h8);
        chk("unhold_addr_c", ImemAddr_o, 32'hC);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h1111_0004, 1'b0, 1'b0, 32'h0);
        chk("hold2_valid", {31'b0, Valid_o}, 32'h1);
        #3 rst_ni = 1'b0;
        #1;
        chk("async_req", {31'b0, ImemReq_o}, 32'h0);
        chk("async_valid", {31'b0, Valid_o}, 32'h0);
        chk("async_instr", Instruction_o, NOP);
        chk("async_pc", Pc_o, 32'h0);
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h2222_0001, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        chk("redir_valid", {31'b0, Valid_o}, 32'h0);
        chk("redir_nop", Instruction_o, NOP);
        chk("drain_req", {31'b0, ImemReq_o}, 32'h0);
        step(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
        chk("drain_discard", {31'b0, Valid_o}, 32'h0);
        chk("redir_addr", ImemAddr_o, 32'h100);
        step(1'b1, 32'h2222_0002, 1'b1, 1'b0, 32'h0);
        chk("redir_pc", Pc_o, 32'h100);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 32'h0000_0200);
        chk("coinc_addr", ImemAddr_o, 32'h200);
        chk("coinc_valid", {31'b0, Valid_o}, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("coinc_no_stale", {31'b0, Valid_o}, 32'h0);
        mem_out = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        req, rv, rdy, redir;
            logic [31:0] rd, rpc;
            req   = m_req();
            rdy   = $urandom_range(0, 3) != 0;
            redir = $urandom_range(0, 11) == 0;
            rpc   = $urandom;
            rd    = $urandom;
            rv    = mem_out && mem_lat == 0;
            if (!mem_out && !req && !m_drain && $urandom_range(0, 15) == 0) rv = 1'b1;
            if (mem_out) begin
                if (rv) mem_out = 1'b0;
                else mem_lat--;
            end else if (req) begin
                mem_out = 1'b1;
                mem_lat = $urandom_range(0, 2);
            end
            step(rv, rd, rdy, redir, rpc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
